// File: rtl/eq_adapt_sequencer.sv
// eq_adapt_sequencer: sweeps equalizer frequency codes, averages eye openings per code and settles on the best one.
module eq_adapt_sequencer #(
  parameter int FREQ_MIN      = 0,
  parameter int FREQ_MAX      = 511,
  parameter int FREQ_STEP     = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int N_AVG         = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] opening,
  input  logic        opening_ready,
  output logic [8:0]  guess_frequency,
  output logic        busy,
  output logic        done,
  output logic [11:0] best_opening,
  output logic        timeout_err
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SH = $clog2(N_AVG);
  localparam logic [2:0] IDLE = 3'd0, SETTLE = 3'd1, MEASURE = 3'd2, COMPARE = 3'd3, STEP = 3'd4, FINISH = 3'd5;
  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [4:0]    ncnt;
  logic [15:0]   acc;
  logic [8:0]    best_code;
  logic          have;
  logic [11:0]   avg;
  logic [9:0]    nxt;
  assign avg  = 12'(acc >> SH);
  assign nxt  = {1'b0, guess_frequency} + 10'(FREQ_STEP);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      scnt            <= '0;
      tcnt            <= '0;
      ncnt            <= '0;
      acc             <= '0;
      best_code       <= 9'(FREQ_MIN);
      have            <= 1'b0;
      guess_frequency <= 9'(FREQ_MIN);
      best_opening    <= '0;
      timeout_err     <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          guess_frequency <= 9'(FREQ_MIN);
          best_code       <= 9'(FREQ_MIN);
          best_opening    <= '0;
          have            <= 1'b0;
          acc             <= '0;
          scnt            <= '0;
          timeout_err     <= 1'b0;
          state           <= SETTLE;
        end
        SETTLE: if (scnt == SW'(SETTLE_CYCLES - 1)) begin
          scnt  <= '0;
          ncnt  <= '0;
          tcnt  <= '0;
          state <= MEASURE;
        end else scnt <= scnt + 1'b1;
        MEASURE: if (opening_ready) begin
          acc  <= acc + 16'(opening);
          ncnt <= ncnt + 5'd1;
          tcnt <= '0;
          if (ncnt == 5'(N_AVG - 1)) state <= COMPARE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          timeout_err     <= 1'b1;
          guess_frequency <= have ? best_code : 9'(FREQ_MIN);
          state           <= IDLE;
        end else tcnt <= tcnt + 1'b1;
        COMPARE: begin
          // strict compare keeps the earlier code on ties
          if (!have || avg > best_opening) begin
            best_opening <= avg;
            best_code    <= guess_frequency;
          end
          have  <= 1'b1;
          state <= STEP;
        end
        STEP: if (nxt > 10'(FREQ_MAX)) state <= FINISH;
        else begin
          guess_frequency <= nxt[8:0];
          acc             <= '0;
          scnt            <= '0;
          state           <= SETTLE;
        end
        FINISH: begin
          guess_frequency <= best_code;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eq_adapt_sequencer.sv
// tb_eq_adapt_sequencer: randomized sweeps against a per-code averaging/argmax reference model.
module tb_eq_adapt_sequencer;
  localparam int SETTLE = 64;
  localparam int NPTS   = 32;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, opening_ready = 0;
  logic [11:0] opening = 0;
  logic [8:0]  guess_frequency;
  logic        busy, done, timeout_err;
  logic [11:0] best_opening;
  logic [11:0] seq [0:511][0:3];
  int          stable = 0, pidx = 0, stop_code = -1, done_cnt = 0, nvec = 0, nerr = 0;
  logic [8:0]  prev_gf = 0;
  logic        prev_busy = 0;
  logic [8:0]  mbc;
  logic [11:0] mba;

  eq_adapt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .opening(opening), .opening_ready(opening_ready),
    .guess_frequency(guess_frequency), .busy(busy), .done(done),
    .best_opening(best_opening), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // eye sensor: strobes only once the code has been stable well past the settle window
  task automatic tick();
    @(posedge clk); #1;
    if (done) done_cnt++;
    if (!busy || !prev_busy || guess_frequency != prev_gf) begin
      stable = 0;
      pidx   = 0;
    end else stable++;
    prev_gf       = guess_frequency;
    prev_busy     = busy;
    opening_ready = 0;
    if (busy && stable >= SETTLE + 2 && int'(guess_frequency) != stop_code && $urandom_range(1, 0) == 1) begin
      opening_ready = 1;
      opening       = pidx < 4 ? seq[guess_frequency][pidx] : 12'($urandom);
      pidx++;
    end
  endtask

  task automatic model(input int npts, output logic [8:0] bc, output logic [11:0] ba);
    int s, a;
    bc = 0;
    ba = 0;
    for (int p = 0; p < npts; p++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(seq[p*16][k]);
      a = s / 4;
      if (p == 0 || a > int'(ba)) begin
        ba = 12'(a);
        bc = 9'(p*16);
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    check(tag, busy, 0);
  endtask

  task automatic wait_gf(input string tag, input int code);
    int n = 0;
    while (int'(guess_frequency) != code && n < 5000) begin tick(); n++; end
    check(tag, guess_frequency, code);
  endtask

  task automatic sweep(input string tag);
    logic [8:0]  bc;
    logic [11:0] ba;
    model(NPTS, bc, ba);
    done_cnt = 0;
    start = 1; tick(); start = 0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_terr_clr"}, timeout_err, 0);
    wait_idle({tag, "_end"}, 20000);
    check({tag, "_gf"}, guess_frequency, bc);
    check({tag, "_best"}, best_opening, ba);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_terr"}, timeout_err, 0);
    repeat (3) tick();
    check({tag, "_hold"}, guess_frequency, bc);
  endtask

  task automatic fill_rand();
    for (int c = 0; c < 512; c++) for (int k = 0; k < 4; k++) seq[c][k] = 12'($urandom);
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1;
    tick();
    check("rst_gf", guess_frequency, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best", best_opening, 0);
    check("rst_terr", timeout_err, 0);

    for (int c = 0; c < 512; c++) for (int k = 0; k < 4; k++) seq[c][k] = 12'(100 + c / 4);
    sweep("mono");
    check("mono_496", guess_frequency, 496);
    check("mono_224", best_opening, 224);

    for (int c = 0; c < 512; c++) for (int k = 0; k < 4; k++) seq[c][k] = 12'(c == 208 || c == 224 ? 900 : 100);
    sweep("peak");
    check("peak_208", guess_frequency, 208);

    for (int c = 0; c < 512; c++) for (int k = 0; k < 4; k++) seq[c][k] = 12'(c == 0 ? 10 + k : 5);
    sweep("trunc");
    check("trunc_11", best_opening, 11);

    for (int r = 0; r < 2; r++) begin
      fill_rand();
      sweep("rand");
    end

    fill_rand();
    model(2, mbc, mba);
    stop_code = 32;
    done_cnt = 0;
    start = 1; tick(); start = 0;
    wait_idle("to_end", 5000);
    check("to_terr", timeout_err, 1);
    check("to_done", done_cnt, 0);
    check("to_gf", guess_frequency, mbc);
    stop_code = -1;
    sweep("after_to");

    fill_rand();
    done_cnt = 0;
    start = 1; tick(); start = 0;
    wait_gf("ab_pt3", 32);
    start = 1; tick(); start = 0;
    check("ab_start_ign_gf", guess_frequency, 32);
    check("ab_start_ign_busy", busy, 1);
    wait_gf("ab_pt5", 64);
    repeat (10) tick();
    abort = 1; tick(); abort = 0;
    check("ab_busy", busy, 0);
    check("ab_gf", guess_frequency, 64);
    repeat (5) tick();
    check("ab_done", done_cnt, 0);
    check("ab_gf_hold", guess_frequency, 64);
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check("sa_busy", busy, 0);
    tick();
    check("sa_busy2", busy, 0);

    fill_rand();
    start = 1; tick(); start = 0;
    wait_gf("rs_pt4", 48);
    while (stable < SETTLE + 10) tick();
    #2 rst_n = 0;
    #1;
    check("rs_gf", guess_frequency, 0);
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_best", best_opening, 0);
    check("rs_terr", timeout_err, 0);
    #3 rst_n = 1;
    tick();
    fill_rand();
    sweep("rs_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
